// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding and default sizing for the keypad lock.
package lock_pkg;
  typedef enum logic [1:0] {IDLE, UNLOCKED, LOCKOUT} state_t;
  localparam int PW_WIDTH = 16;
  localparam int MAX_FAIL_DEFAULT = 3;
endpackage

// File: rtl/checking_pass_if.sv
// checking_pass_if: code entry, compare request and lock/reset outputs.
interface checking_pass_if import lock_pkg::*; #(parameter int WIDTH = PW_WIDTH);
  logic [WIDTH-1:0] pw_16bit;
  logic [WIDTH-1:0] password;
  logic enb_cmp;
  logic enb_lock;
  logic gen_rst;
  modport master (output pw_16bit, password, enb_cmp, input enb_lock, gen_rst);
  modport slave (input pw_16bit, password, enb_cmp, output enb_lock, gen_rst);
endinterface

// File: rtl/checking_pass.sv
// checking_pass: password compare, consecutive-failure counter and lockout FSM.
module checking_pass import lock_pkg::*; #(
  parameter int WIDTH = PW_WIDTH,
  parameter int MAX_FAIL = MAX_FAIL_DEFAULT
) (
  input logic clk,
  input logic reset,
  checking_pass_if.slave bus
);
  localparam int CW = $clog2(MAX_FAIL + 1);
  state_t state, state_nxt;
  logic [CW-1:0] fail_cnt, fail_nxt;
  logic [WIDTH-1:0] code, ref_code;
  logic enb_cmp_q, cmp_evt, match;
  assign code = bus.pw_16bit;
  assign ref_code = bus.password;
  assign cmp_evt = bus.enb_cmp & ~enb_cmp_q;
  assign match = code == ref_code;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      fail_cnt <= '0;
      enb_cmp_q <= 1'b0;
    end else begin
      state <= state_nxt;
      fail_cnt <= fail_nxt;
      enb_cmp_q <= bus.enb_cmp;
    end
  end
  // lockout swallows every event; only reset leaves it
  always_comb begin
    state_nxt = state;
    fail_nxt = fail_cnt;
    if (cmp_evt && state != LOCKOUT) begin
      if (match) begin
        state_nxt = UNLOCKED;
        fail_nxt = '0;
      end else if (fail_cnt + CW'(1) == CW'(MAX_FAIL)) begin
        state_nxt = LOCKOUT;
        fail_nxt = CW'(MAX_FAIL);
      end else begin
        state_nxt = IDLE;
        fail_nxt = fail_cnt + CW'(1);
      end
    end
  end
  assign bus.enb_lock = state == UNLOCKED;
  assign bus.gen_rst = state == LOCKOUT;
endmodule

// File: tb/tb_checking_pass.sv
// tb_checking_pass: directed vectors with a queued scoreboard and a negedge monitor.
module tb_checking_pass;
  typedef struct {
    int due;
    string nm;
    logic lock;
    logic rst;
    int cnt;
  } sb_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  sb_t q[$];
  sb_t e;
  checking_pass_if #(.WIDTH(16)) bus ();
  checking_pass dut (.clk(clk), .reset(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      total++;
      if (bus.enb_lock !== e.lock || bus.gen_rst !== e.rst || int'(dut.fail_cnt) != e.cnt) begin
        bad++;
        $display("FAIL %s: got lock=%0b rst=%0b cnt=%0d, want lock=%0b rst=%0b cnt=%0d",
                 e.nm, bus.enb_lock, bus.gen_rst, dut.fail_cnt, e.lock, e.rst, e.cnt);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_now(input string nm, input logic l, input logic r, input int c);
    q.push_back('{cyc, nm, l, r, c});
  endtask
  task automatic do_reset(input int n, input string nm);
    rst_n = 1'b0;
    repeat (n) step();
    expect_now(nm, 1'b0, 1'b0, 0);
    step();
    rst_n = 1'b1;
  endtask
  task automatic pulse(input logic [15:0] p, input string nm, input logic l, input logic r, input int c);
    bus.pw_16bit = p;
    bus.enb_cmp = 1'b1;
    step();
    bus.enb_cmp = 1'b0;
    expect_now(nm, l, r, c);
    step();
  endtask
  initial begin
    bus.pw_16bit = 16'h0000;
    bus.password = 16'h0000;
    bus.enb_cmp = 1'b0;
    step();
    do_reset(2, "reset_init");
    pulse(16'h0000, "zero_match", 1'b1, 1'b0, 0);
    bus.pw_16bit = 16'h1234;
    step();
    expect_now("hold_no_event", 1'b1, 1'b0, 0);
    step();
    pulse(16'h1234, "relock_wrong", 1'b0, 1'b0, 1);
    do_reset(1, "reset_before_lockout");
    pulse(16'h1234, "wrong1", 1'b0, 1'b0, 1);
    pulse(16'h1234, "wrong2", 1'b0, 1'b0, 2);
    pulse(16'h1234, "wrong3_lockout", 1'b0, 1'b1, 3);
    pulse(16'h1234, "wrong4_ignored", 1'b0, 1'b1, 3);
    for (int i = 0; i < 4; i++) pulse(16'h0000, $sformatf("correct_ignored%0d", i), 1'b0, 1'b1, 3);
    do_reset(1, "reset_clears_lockout");
    pulse(16'h0000, "unlock_after_reset", 1'b1, 1'b0, 0);
    bus.password = 16'hA5C3;
    pulse(16'hA5C2, "lsb_diff_wrong", 1'b0, 1'b0, 1);
    pulse(16'h25C3, "msb_diff_wrong", 1'b0, 1'b0, 2);
    pulse(16'hA5C3, "full_match", 1'b1, 1'b0, 0);
    pulse(16'h1234, "mix_wrong1", 1'b0, 1'b0, 1);
    pulse(16'h1234, "mix_wrong2", 1'b0, 1'b0, 2);
    pulse(16'hA5C3, "mix_correct", 1'b1, 1'b0, 0);
    pulse(16'h1234, "mix_wrong3", 1'b0, 1'b0, 1);
    pulse(16'h1234, "mix_wrong4", 1'b0, 1'b0, 2);
    do_reset(1, "reset_before_hold");
    bus.pw_16bit = 16'h1234;
    bus.enb_cmp = 1'b1;
    step();
    expect_now("hold_first_edge", 1'b0, 1'b0, 1);
    repeat (9) step();
    expect_now("hold_ten_cycles", 1'b0, 1'b0, 1);
    bus.enb_cmp = 1'b0;
    step();
    bus.pw_16bit = 16'hA5C3;
    rst_n = 1'b0;
    bus.enb_cmp = 1'b1;
    step();
    expect_now("edge_during_reset", 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    bus.enb_cmp = 1'b0;
    step();
    expect_now("after_reset_edge", 1'b0, 1'b0, 0);
    repeat (3) step();
    if (q.size() != 0) begin
      total += q.size();
      bad += q.size();
      $display("FAIL scoreboard_drain: got pending=%0d, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
